// File: rtl/cbc_decrypt_stream.sv
// Streaming CBC decryptor: PT = CT ^ expanded key ^ previous CT (IV for the first block),
// delivered through a one-deep registered output stage with full backpressure.
module cbc_decrypt_stream #(
   parameter int BLOCK_SIZE = 8,
   parameter int SYNC_SIZE  = 32,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BLOCK_SIZE-1:0] key,
   input  logic [SYNC_SIZE-1:0]  iv,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SYNC_SIZE-1:0]  in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SYNC_SIZE-1:0]  out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic [CNT_W-1:0]      blk_count
);

   // state | meaning
   // IDLE  | waiting for start; no beats accepted
   // RUN   | accepting ciphertext until the last beat is taken
   // DRAIN | last plaintext beat waiting for the consumer
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_SIZE-1:0]   r_chain;
   logic [SYNC_SIZE-1:0]   r_out_data;
   logic                   r_out_valid;
   logic                   r_out_last;
   logic [CNT_W-1:0]       r_blk_count;
   logic [SYNC_SIZE-1:0]   w_kexp;
   logic                   w_accept;
   logic                   w_start_ok;
   logic                   w_out_hs;

   // The key is tiled across the data width.
   for (genvar gi = 0; gi < SYNC_SIZE; gi++) begin : g_kexp
      assign w_kexp[gi] = key[gi % BLOCK_SIZE];
   end

   assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_start_ok = (r_state == ST_IDLE) && start;
   assign w_out_hs   = r_out_valid && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_RUN;
         ST_RUN:   if (w_accept && in_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_out_hs && r_out_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_blk_count <= '0;
      end else begin
         if (w_start_ok) begin
            r_chain     <= iv;
            r_blk_count <= '0;
         end
         // A same-cycle output handshake and accept simply reloads the stage.
         if (w_accept) begin
            r_out_data  <= in_data ^ w_kexp ^ r_chain;
            r_out_last  <= in_last;
            r_out_valid <= 1'b1;
            r_chain     <= in_data;
            if (r_blk_count != '1) r_blk_count <= r_blk_count + CNT_ONE;
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = (r_state != ST_IDLE);
   assign blk_count = r_blk_count;

endmodule

// File: tb/tb_cbc_decrypt_stream.sv
// Self-checking bench for cbc_decrypt_stream: directed vectors plus random loop-back
// messages checked against an in-bench CBC encrypt/decrypt reference.
module tb_cbc_decrypt_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key = 4'hA;
   logic [7:0] iv = '0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;

   logic        in_ready, out_valid, out_last, busy;
   logic [7:0]  out_data;
   logic [15:0] blk_count;
   logic        in_ready2, out_valid2, out_last2, busy2;
   logic [7:0]  out_data2;
   logic [1:0]  blk_count2;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] q_ct[$];
   logic [7:0] q_pt[$];

   always #5 clk = ~clk;

   cbc_decrypt_stream #(.BLOCK_SIZE(4), .SYNC_SIZE(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .blk_count(blk_count)
   );

   cbc_decrypt_stream #(.BLOCK_SIZE(4), .SYNC_SIZE(8), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .start(start),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2),
      .busy(busy2), .blk_count(blk_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [7:0] kexp(input logic [3:0] k);
      return {k, k};
   endfunction

   // Reference encryption: CT[n] = PT[n] ^ KEXP ^ chain, chain = IV then CT[n-1].
   task automatic build_random(input int n, input logic [7:0] iv_v, input logic [3:0] k);
      logic [7:0] chain = iv_v;
      logic [7:0] p;
      q_ct.delete(); q_pt.delete();
      for (int i = 0; i < n; i++) begin
         p = 8'($urandom);
         q_pt.push_back(p);
         q_ct.push_back(p ^ kexp(k) ^ chain);
         chain = q_ct[i];
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the last handshake.
   task automatic run_msg(input logic [7:0] iv_v, input int rdy_mode, input int vld_pct,
                          input bit start_mid, input bit start_end);
      int n = q_ct.size();
      int sent = 0, rcvd = 0, cyc = 0, stall = 0;
      bit holding = 0, mid_done = 0;
      logic [7:0] hold_d;
      logic hold_l;
      start = 1'b1; iv = iv_v;
      @(negedge clk);
      start = 1'b0; iv = 8'($urandom);
      check("busy_after_start", busy, 1);
      while (rcvd < n && cyc < 2000) begin
         in_valid = (sent < n) && ($urandom_range(99) < vld_pct);
         in_data  = (sent < n) ? q_ct[sent] : 8'($urandom);
         in_last  = (sent == n - 1);
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(99) < 70);
            default: begin
               out_ready = !(out_valid && stall < 3);
               if (out_valid && !out_ready) stall++;
            end
         endcase
         start = 1'b0;
         if (start_mid && sent == 1 && !mid_done) begin
            start = 1'b1; iv = 8'hFF; mid_done = 1;
         end
         if (start_end && rcvd == n - 1 && out_valid && out_ready) start = 1'b1;
         #1;
         if (holding) begin
            check("hold_data", out_data, hold_d);
            check("hold_last", out_last, hold_l);
         end
         check("in_ready", in_ready, (sent < n) && (!out_valid || out_ready));
         if (out_valid && out_ready) begin
            check("out_data", out_data, q_pt[rcvd]);
            check("out_last", out_last, rcvd == n - 1);
            check("sat_out_data", out_data2, q_pt[rcvd]);
            rcvd++;
         end
         holding = out_valid && !out_ready;
         hold_d  = out_data;
         hold_l  = out_last;
         if (in_valid && in_ready) sent++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      check("msg_complete", rcvd, n);
      check("busy_fall", busy, 0);
      check("out_valid_clear", out_valid, 0);
      check("blk_count", blk_count, n);
      check("blk_count_sat", blk_count2, (n > 3) ? 3 : n);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_blk_count", blk_count, 0);
      check("rst_in_ready", in_ready, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // in_valid while IDLE is never accepted
      in_valid = 1'b1; in_data = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("idle_in_ready", in_ready, 0);
         @(negedge clk);
      end
      check("idle_no_out", out_valid, 0);
      in_valid = 1'b0;

      // Directed two-block message, free-flowing consumer
      key = 4'hA;
      q_ct = '{8'h3C, 8'h55}; q_pt = '{8'h99, 8'hC3};
      run_msg(8'h0F, 0, 100, 0, 0);

      // Same stream with three stall cycles after the first beat
      run_msg(8'h0F, 2, 100, 0, 0);

      // Start pulsed in RUN and on the closing handshake are both ignored
      run_msg(8'h0F, 0, 100, 1, 1);

      // Single-block message
      q_ct = '{8'h3C}; q_pt = '{8'h99};
      run_msg(8'h0F, 0, 100, 0, 0);

      // Reset mid-message after two beats
      start = 1'b1; iv = 8'h0F; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
      @(negedge clk);
      in_data = 8'h11;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_last", out_last, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_blk_count", blk_count, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      q_ct = '{8'h3C}; q_pt = '{8'h99};
      run_msg(8'h0F, 0, 100, 0, 0);

      // Five-block message: narrow counter saturates, data path unaffected
      build_random(5, 8'h0F, 4'hA);
      run_msg(8'h0F, 1, 80, 0, 0);

      // Random loop-back messages with random key, IV and handshake timing
      for (int t = 0; t < 6; t++) begin
         logic [7:0] riv;
         riv = 8'($urandom);
         key = 4'($urandom);
         build_random((t == 0) ? 16 : $urandom_range(1, 20), riv, key);
         run_msg(riv, 1, $urandom_range(40, 100), 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
